speed_tick_gen: RTL and testbench

Multi-channel programmable tick generator for game-speed timing: the parametrised successor to the single-channel speed divider. Each channel runs its own period counter. A channel emits a one-cycle `tick` pulse and a toggling `div_clk` square wave, and accepts runtime period loads and "hit" strobes that shorten its period by a fixed fraction down to a floor. Sits between the system clock and the ball/paddle motion logic; one channel per moving object.

---
 rtl/speed_tick_gen.sv | 77 +++++++
 tb/tb_speed_tick_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/speed_tick_gen.sv
// Multi-channel programmable tick generator for game-speed timing.
// Each channel has its own period counter, tick pulse, div_clk and hit speed-up.
module speed_tick_gen #(
    parameter int               WIDTH        = 26,
    parameter int               CHANNELS     = 2,
    parameter logic [WIDTH-1:0] RESET_PERIOD = 26'd3_124_999,
    parameter logic [WIDTH-1:0] MIN_PERIOD   = 26'd100_000,
    parameter int               SHIFT        = 3
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       load,
    input  logic [WIDTH-1:0]          load_period,
    input  logic [CHANNELS-1:0]       hit,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       div_clk,
    output logic [CHANNELS*WIDTH-1:0] period
);

    logic [WIDTH-1:0] w_load_val;

    assign w_load_val = (load_period < MIN_PERIOD) ? MIN_PERIOD : load_period;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_period;
        logic             r_tick;
        logic             r_div;
        logic [WIDTH-1:0] w_shr;
        logic [WIDTH-1:0] w_dec;
        logic [WIDTH:0]   w_diff;
        logic [WIDTH-1:0] w_hit_period;

        assign w_shr = r_period >> SHIFT;
        assign w_dec = (w_shr == '0) ? WIDTH'(1) : w_shr;

        // Extra MSB catches a borrow so a tiny period never wraps to a huge one
        assign w_diff = {1'b0, r_period} - {1'b0, w_dec};
        assign w_hit_period =
            (w_diff[WIDTH] || (w_diff[WIDTH-1:0] < MIN_PERIOD)) ?
            MIN_PERIOD : w_diff[WIDTH-1:0];

        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                r_period <= RESET_PERIOD;
                r_cnt    <= '0;
                r_tick   <= 1'b0;
                r_div    <= 1'b0;
            end else if (load[g]) begin
                r_period <= w_load_val;
                r_cnt    <= '0;
                r_tick   <= 1'b0;
            end else begin
                if (hit[g]) begin
                    r_period <= w_hit_period;
                end
                if (!en) begin
                    r_tick <= 1'b0;
                end else if (r_cnt >= r_period) begin
                    // >= also catches a period that shrank below the count
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    r_div  <= ~r_div;
                end else begin
                    r_cnt  <= r_cnt + WIDTH'(1);
                    r_tick <= 1'b0;
                end
            end
        end

        assign tick[g]                 = r_tick;
        assign div_clk[g]              = r_div;
        assign period[g*WIDTH +: WIDTH] = r_period;
    end

endmodule

// File: tb/tb_speed_tick_gen.sv
// Directed bench for speed_tick_gen with small periods.
// Checks reset, cadence, loads, hits, enable hold and async reset.
module tb_speed_tick_gen;

    localparam int W  = 8;
    localparam int CH = 2;

    logic          clk_in = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [CH-1:0] load = '0;
    logic [W-1:0]  load_period = '0;
    logic [CH-1:0] hit = '0;
    logic [CH-1:0] tick;
    logic [CH-1:0] div_clk;
    logic [CH*W-1:0] period;

    int checks = 0;
    int errors = 0;

    speed_tick_gen #(
        .WIDTH(W),
        .CHANNELS(CH),
        .RESET_PERIOD(8'd9),
        .MIN_PERIOD(8'd2),
        .SHIFT(2)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .en(en),
        .load(load),
        .load_period(load_period),
        .hit(hit),
        .tick(tick),
        .div_clk(div_clk),
        .period(period)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts negedges until tick[ch] is seen; 100 means it never came
    task automatic wait_tick(input int ch, output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!tick[ch] && n < 100);
    endtask

    initial begin
        int n;
        logic [CH-1:0] any_tick;
        logic [CH-1:0] div_before;
        int exp_seq[7] = '{7, 6, 5, 4, 3, 2, 2};

        #1 rst = 1'b1;
        #1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_div", 32'(div_clk), 32'd0);
        chk("rst_period", 32'(period), 32'h0909);

        // Release and check 10-cycle cadence on both channels
        @(negedge clk_in);
        rst = 1'b0;
        en  = 1'b1;
        wait_tick(0, n);
        chk("first_tick_lat", n, 10);
        chk("first_tick_both", 32'(tick), 32'd3);
        chk("first_div_rise", 32'(div_clk), 32'd3);
        wait_tick(0, n);
        chk("tick_interval", n, 10);
        chk("div_fall", 32'(div_clk), 32'd0);

        // Load ch0 with 3 mid-phase; ch1 cadence untouched
        repeat (3) @(negedge clk_in);
        load = 2'b01;
        load_period = 8'd3;
        @(negedge clk_in);
        load = '0;
        load_period = 8'd77;
        chk("load_ch0_period", 32'(period[0 +: W]), 32'd3);
        wait_tick(0, n);
        chk("load_first_tick", n, 4);
        wait_tick(0, n);
        chk("load_interval", n, 4);
        wait_tick(1, n);
        chk("ch1_unaffected", n, 8);
        chk("ch1_period_keep", 32'(period[W +: W]), 32'd9);

        // Repeated hits on ch1 down to the floor
        for (int k = 0; k < 7; k++) begin
            hit = 2'b10;
            @(negedge clk_in);
            chk($sformatf("hit_seq%0d", k), 32'(period[W +: W]), exp_seq[k]);
        end
        hit = '0;
        chk("hit_ch0_indep", 32'(period[0 +: W]), 32'd3);

        // Load of 0 clamps; load beats a same-cycle hit
        load = 2'b10;
        load_period = 8'd0;
        @(negedge clk_in);
        load = '0;
        chk("load_clamp", 32'(period[W +: W]), 32'd2);
        load = 2'b10;
        load_period = 8'd5;
        hit = 2'b10;
        @(negedge clk_in);
        load = '0;
        hit = '0;
        chk("load_wins_hit", 32'(period[W +: W]), 32'd5);
        chk("ch0_after_ch1_load", 32'(period[0 +: W]), 32'd3);

        // ch0 period 9, hit late in the count -> immediate wrap
        load = 2'b01;
        load_period = 8'd9;
        @(negedge clk_in);
        load = '0;
        repeat (7) @(negedge clk_in);
        hit = 2'b01;
        @(negedge clk_in);
        hit = '0;
        chk("hit_late_period", 32'(period[0 +: W]), 32'd7);
        chk("hit_late_notick", 32'(tick[0]), 32'd0);
        @(negedge clk_in);
        chk("hit_late_wrap", 32'(tick[0]), 32'd1);
        wait_tick(0, n);
        chk("hit_new_interval", n, 8);

        // Enable held low for 5 cycles mid-count
        repeat (3) @(negedge clk_in);
        en = 1'b0;
        div_before = div_clk;
        any_tick = '0;
        repeat (5) begin
            @(negedge clk_in);
            any_tick |= tick;
        end
        chk("hold_no_tick", 32'(any_tick), 32'd0);
        chk("hold_div", 32'(div_clk), 32'(div_before));
        en = 1'b1;
        wait_tick(0, n);
        chk("hold_delay", n, 5);

        // Async reset mid-cycle
        repeat (3) @(negedge clk_in);
        #2 rst = 1'b1;
        #1;
        chk("async_tick", 32'(tick), 32'd0);
        chk("async_div", 32'(div_clk), 32'd0);
        chk("async_period", 32'(period), 32'h0909);
        @(negedge clk_in);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
